// File: rtl/p_hardisc.sv
// ---------------------------------------------------------------------------
// p_hardisc : shared types, HTRANS encodings and SECDED encoder for AHB responders
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package p_hardisc;

  typedef enum logic [2:0] {
    RESP_IDLE = 3'd0,
    RESP_RD   = 3'd1,
    RESP_WR   = 3'd2,
    RESP_RAW  = 3'd3,
    RESP_ERR1 = 3'd4,
    RESP_ERR2 = 3'd5
  } ahb_resp_fsm;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Hamming positions 1..38 skipping powers of two carry the data bits;
  // bit 6 is the overall parity over data and the six Hamming bits.
  function automatic logic [6:0] secded_encode(input logic [31:0] data);
    logic [6:0] c;
    logic [4:0] k;
    c = '0;
    k = '0;
    for (logic [5:0] pos = 6'd1; pos < 6'd39; pos = pos + 6'd1) begin
      if ((pos & (pos - 6'd1)) != 6'd0) begin
        for (int i = 0; i < 6; i++) begin
          if (((pos >> i) & 6'd1) != 6'd0) c[i] = c[i] ^ data[k];
        end
        k = k + 5'd1;
      end
    end
    c[6] = (^data) ^ (^c[5:0]);
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_parity_check.sv
// ---------------------------------------------------------------------------
// ahb_parity_check : even parity over AHB address/control, with mismatch flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ahb_parity_check (
  input  logic [31:0] haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic [2:0]  hsize_i,
  input  logic        hwrite_i,
  input  logic [5:0]  hparity_i,
  output logic [5:0]  exp_parity_o,
  output logic        mismatch_o
);

  always_comb begin
    exp_parity_o[0] = ^haddr_i[7:0];
    exp_parity_o[1] = ^haddr_i[15:8];
    exp_parity_o[2] = ^haddr_i[23:16];
    exp_parity_o[3] = ^haddr_i[31:24];
    exp_parity_o[4] = (^hsize_i) ^ hwrite_i;
    exp_parity_o[5] = ^htrans_i;
    mismatch_o      = (exp_parity_o != hparity_i);
  end

endmodule

`default_nettype wire

// File: rtl/ahb_mem_responder.sv
// ---------------------------------------------------------------------------
// ahb_mem_responder : AHB-Lite responder in front of a 32+7 bit SRAM word array
// Optional write-checksum verification: define AHB_MEM_WCHECK_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ahb_mem_responder
  import p_hardisc::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                s_clk_i,
  input  logic                s_reset_i,
  input  logic                s_hsel_i,
  input  logic [31:0]         s_haddr_i,
  input  logic [1:0]          s_htrans_i,
  input  logic [2:0]          s_hsize_i,
  input  logic                s_hwrite_i,
  input  logic                s_hready_i,
  input  logic [5:0]          s_hparity_i,
  input  logic [31:0]         s_hwdata_i,
  input  logic [6:0]          s_hwdcheck_i,
  output logic [31:0]         s_hrdata_o,
  output logic [6:0]          s_hrdcheck_o,
  output logic                s_hreadyout_o,
  output logic                s_hresp_o,
  output logic                s_mem_en_o,
  output logic                s_mem_we_o,
  output logic [3:0]          s_mem_be_o,
  output logic [ADDR_W-1:0]   s_mem_addr_o,
  output logic [31:0]         s_mem_wdata_o,
  output logic [6:0]          s_mem_wcheck_o,
  input  logic [31:0]         s_mem_rdata_i,
  input  logic [6:0]          s_mem_rcheck_i,
  output logic [ERRCNT_W-1:0] s_err_cnt_o
);

  ahb_resp_fsm         state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          off_q, off_d;
  logic [ERRCNT_W-1:0] cnt_q;

  logic [5:0] w_exp_parity;
  logic       w_par_err;
  logic       w_ap;
  logic       w_bad;
  logic       w_misalign;
  logic       w_wchk_err;
  logic       w_err_evt;
  logic [3:0] w_be;

  ahb_parity_check u_parity (
    .haddr_i      (s_haddr_i),
    .htrans_i     (s_htrans_i),
    .hsize_i      (s_hsize_i),
    .hwrite_i     (s_hwrite_i),
    .hparity_i    (s_hparity_i),
    .exp_parity_o (w_exp_parity),
    .mismatch_o   (w_par_err)
  );

  assign w_ap = s_hsel_i & s_hready_i & ((s_htrans_i & HTRANS_NONSEQ) != HTRANS_IDLE);

  assign w_misalign = ((s_hsize_i == 3'd1) &  s_haddr_i[0]) |
                      ((s_hsize_i == 3'd2) & (s_haddr_i[1:0] != 2'b00));

  assign w_bad = w_par_err | (s_hsize_i > 3'd2) | w_misalign |
                 (|s_haddr_i[31:ADDR_W+2]);

`ifdef AHB_MEM_WCHECK_EN
  assign w_wchk_err = (state_q == RESP_WR) &&
                      (secded_encode(s_hwdata_i) != s_hwdcheck_i);
`else
  assign w_wchk_err = 1'b0;
`endif

  always_comb begin
    case (size_q)
      2'd0:    w_be = 4'b0001 << off_q;
      2'd1:    w_be = off_q[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d        = RESP_IDLE;
    addr_d         = addr_q;
    size_d         = size_q;
    off_d          = off_q;
    s_mem_en_o     = 1'b0;
    s_mem_we_o     = 1'b0;
    s_mem_be_o     = 4'b0000;
    s_mem_addr_o   = '0;
    s_mem_wdata_o  = '0;
    s_mem_wcheck_o = '0;
    case (state_q)
      RESP_RAW: begin
        s_mem_en_o   = 1'b1;
        s_mem_addr_o = addr_q;
        state_d      = RESP_RD;
      end
      RESP_ERR1: state_d = RESP_ERR2;
      default: begin
        if (state_q == RESP_WR && !w_wchk_err) begin
          s_mem_en_o     = 1'b1;
          s_mem_we_o     = 1'b1;
          s_mem_be_o     = w_be;
          s_mem_addr_o   = addr_q;
          s_mem_wdata_o  = s_hwdata_i;
          s_mem_wcheck_o = s_hwdcheck_i;
        end
        if (w_wchk_err) begin
          state_d = RESP_ERR2;
        end else if (w_ap) begin
          if (w_bad) begin
            state_d = RESP_ERR1;
          end else if (s_hwrite_i) begin
            addr_d  = s_haddr_i[ADDR_W+1:2];
            size_d  = s_hsize_i[1:0];
            off_d   = s_haddr_i[1:0];
            state_d = RESP_WR;
          end else if (state_q == RESP_WR) begin
            // SRAM port is busy with the write; replay the read next cycle.
            addr_d  = s_haddr_i[ADDR_W+1:2];
            state_d = RESP_RAW;
          end else begin
            s_mem_en_o   = 1'b1;
            s_mem_addr_o = s_haddr_i[ADDR_W+1:2];
            state_d      = RESP_RD;
          end
        end
      end
    endcase
  end

  assign w_err_evt = (state_d == RESP_ERR1) | w_wchk_err;

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      state_q <= RESP_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      off_q   <= off_d;
      if (w_err_evt && cnt_q != {ERRCNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign s_hreadyout_o = !((state_q == RESP_RAW) || (state_q == RESP_ERR1) || w_wchk_err);
  assign s_hresp_o     = (state_q == RESP_ERR1) || (state_q == RESP_ERR2) || w_wchk_err;
  assign s_hrdata_o    = (state_q == RESP_RD) ? s_mem_rdata_i  : 32'd0;
  assign s_hrdcheck_o  = (state_q == RESP_RD) ? s_mem_rcheck_i : 7'd0;
  assign s_err_cnt_o   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_ahb_mem_responder : self-checking bench with SRAM model and read scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ahb_mem_responder;
  import p_hardisc::*;

  localparam int ADDR_W   = 12;
  localparam int ERRCNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic hsel, hwrite, hready;
  logic [31:0] haddr, hwdata, hrdata, mem_wdata, mem_rdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [5:0]  hparity;
  logic [6:0]  hwdcheck, hrdcheck, mem_wcheck, mem_rcheck;
  logic hreadyout, hresp, mem_en, mem_we;
  logic [3:0] mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [ERRCNT_W-1:0] err_cnt;

  typedef struct packed { logic [31:0] d; logic [6:0] c; } rd_t;
  rd_t sb[$];
  rd_t e;

  int n_pass = 0;
  int n_tot  = 0;

  logic [31:0] ram_d [0:(1<<ADDR_W)-1];
  logic [6:0]  ram_c [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;
  assign hready = hreadyout;

  ahb_mem_responder #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) dut (
    .s_clk_i(clk), .s_reset_i(rst), .s_hsel_i(hsel), .s_haddr_i(haddr),
    .s_htrans_i(htrans), .s_hsize_i(hsize), .s_hwrite_i(hwrite),
    .s_hready_i(hready), .s_hparity_i(hparity), .s_hwdata_i(hwdata),
    .s_hwdcheck_i(hwdcheck), .s_hrdata_o(hrdata), .s_hrdcheck_o(hrdcheck),
    .s_hreadyout_o(hreadyout), .s_hresp_o(hresp), .s_mem_en_o(mem_en),
    .s_mem_we_o(mem_we), .s_mem_be_o(mem_be), .s_mem_addr_o(mem_addr),
    .s_mem_wdata_o(mem_wdata), .s_mem_wcheck_o(mem_wcheck),
    .s_mem_rdata_i(mem_rdata), .s_mem_rcheck_i(mem_rcheck), .s_err_cnt_o(err_cnt)
  );

  // SRAM model: byte-masked data write, whole checksum write, 1-cycle read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram_d[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        ram_c[mem_addr] <= mem_wcheck;
      end else begin
        mem_rdata  <= ram_d[mem_addr];
        mem_rcheck <= ram_c[mem_addr];
      end
    end
  end

  function automatic logic [5:0] par(input logic [31:0] a, input logic [1:0] t,
                                     input logic [2:0] s, input logic w);
    return {^t, (^s) ^ w, ^a[31:24], ^a[23:16], ^a[15:8], ^a[7:0]};
  endfunction

  task automatic ap(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = a; hsize = sz; hwrite = wr;
    hparity = par(a, HTRANS_NONSEQ, sz, wr);
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hsize = '0; hwrite = 1'b0;
    hparity = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); hwdata = '0; hwdcheck = '0;
    step(); step();
    @(negedge clk);
    n_tot++; if (hreadyout !== 1'b1) $display("FAIL rst_hreadyout got %b exp 1", hreadyout); else n_pass++;
    n_tot++; if (hresp !== 1'b0) $display("FAIL rst_hresp got %b exp 0", hresp); else n_pass++;
    n_tot++; if (mem_en !== 1'b0) $display("FAIL rst_mem_en got %b exp 0", mem_en); else n_pass++;
    n_tot++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt got %0d exp 0", err_cnt); else n_pass++;
    n_tot++; if ({hrdata, hrdcheck} !== 39'd0) $display("FAIL rst_hrdata got %h exp 0", hrdata); else n_pass++;
    step(); rst = 1'b0;
  endtask

  task automatic test_word_write_read();
    ap(1'b1, 32'h10, 3'd2);
    step(); idle(); hwdata = 32'hDEADBEEF; hwdcheck = 7'h2A;
    @(negedge clk);
    n_tot++; if ({mem_en, mem_we, mem_be, mem_addr} !== {1'b1, 1'b1, 4'b1111, 12'd4})
      $display("FAIL ww_mem got en%b we%b be%b a%0d exp en1 we1 be1111 a4", mem_en, mem_we, mem_be, mem_addr); else n_pass++;
    n_tot++; if ({mem_wdata, mem_wcheck} !== {32'hDEADBEEF, 7'h2A})
      $display("FAIL ww_wdata got %h/%h exp deadbeef/2a", mem_wdata, mem_wcheck); else n_pass++;
    step(); hwdata = '0; hwdcheck = '0;
    @(negedge clk);
    n_tot++; if ({hreadyout, mem_en} !== 2'b10) $display("FAIL ww_idle got rdy%b en%b exp rdy1 en0", hreadyout, mem_en); else n_pass++;
    step(); ap(1'b0, 32'h10, 3'd2); sb.push_back('{32'hDEADBEEF, 7'h2A});
    @(negedge clk);
    n_tot++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 12'd4})
      $display("FAIL wr_rdissue got en%b we%b a%0d exp en1 we0 a4", mem_en, mem_we, mem_addr); else n_pass++;
    step(); idle();
    @(negedge clk);
    e = (sb.size() != 0) ? sb.pop_front() : '{32'hx, 7'hx};
    n_tot++; if ({hreadyout, hrdata, hrdcheck} !== {1'b1, e.d, e.c})
      $display("FAIL wr_rdata got rdy%b %h/%h exp rdy1 %h/%h", hreadyout, hrdata, hrdcheck, e.d, e.c); else n_pass++;
    step();
  endtask

  task automatic test_raw();
    ap(1'b1, 32'h13, 3'd0);
    step(); ap(1'b0, 32'h10, 3'd2); hwdata = 32'h5A000000; hwdcheck = 7'h11;
    sb.push_back('{32'h5AADBEEF, 7'h11});
    @(negedge clk);
    n_tot++; if ({hreadyout, mem_we, mem_be} !== {1'b1, 1'b1, 4'b1000})
      $display("FAIL raw_be got rdy%b we%b be%b exp rdy1 we1 be1000", hreadyout, mem_we, mem_be); else n_pass++;
    step(); idle(); hwdata = '0; hwdcheck = '0;
    @(negedge clk);
    n_tot++; if ({hreadyout, hresp, mem_en, mem_we, mem_addr} !== {1'b0, 1'b0, 1'b1, 1'b0, 12'd4})
      $display("FAIL raw_wait got rdy%b resp%b en%b we%b a%0d exp 0 0 1 0 4", hreadyout, hresp, mem_en, mem_we, mem_addr); else n_pass++;
    step();
    @(negedge clk);
    e = (sb.size() != 0) ? sb.pop_front() : '{32'hx, 7'hx};
    n_tot++; if ({hreadyout, hrdata, hrdcheck} !== {1'b1, e.d, e.c})
      $display("FAIL raw_rdata got rdy%b %h/%h exp rdy1 %h/%h", hreadyout, hrdata, hrdcheck, e.d, e.c); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat [3];
    pat[0] = 32'h11111111; pat[1] = 32'h22222222; pat[2] = 32'h33333333;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) ap(1'b1, 32'h20 + 32'(4*i), 3'd2); else idle();
      if (i > 0) begin
        hwdata = pat[i-1]; hwdcheck = 7'(i);
        @(negedge clk);
        n_tot++; if ({hreadyout, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'(7+i), pat[i-1]})
          $display("FAIL b2b_wr%0d got rdy%b we%b a%0d d%h exp rdy1 we1 a%0d d%h", i, hreadyout, mem_we, mem_addr, mem_wdata, 7+i, pat[i-1]); else n_pass++;
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        ap(1'b0, 32'h20 + 32'(4*i), 3'd2); sb.push_back('{pat[i], 7'(i+1)});
      end else idle();
      if (i > 0) begin
        @(negedge clk);
        e = (sb.size() != 0) ? sb.pop_front() : '{32'hx, 7'hx};
        n_tot++; if ({hreadyout, hrdata, hrdcheck} !== {1'b1, e.d, e.c})
          $display("FAIL b2b_rd%0d got rdy%b %h/%h exp rdy1 %h/%h", i, hreadyout, hrdata, hrdcheck, e.d, e.c); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_parity_err();
    ap(1'b0, 32'h10, 3'd2); hparity[2] = ~hparity[2];
    @(negedge clk);
    n_tot++; if (mem_en !== 1'b0) $display("FAIL par_mem_en got %b exp 0", mem_en); else n_pass++;
    step(); idle();
    @(negedge clk);
    n_tot++; if ({hreadyout, hresp, mem_en} !== 3'b010) $display("FAIL par_err1 got rdy%b resp%b en%b exp 0 1 0", hreadyout, hresp, mem_en); else n_pass++;
    n_tot++; if (err_cnt !== 8'd1) $display("FAIL par_cnt got %0d exp 1", err_cnt); else n_pass++;
    step();
    @(negedge clk);
    n_tot++; if ({hreadyout, hresp, mem_en} !== 3'b110) $display("FAIL par_err2 got rdy%b resp%b en%b exp 1 1 0", hreadyout, hresp, mem_en); else n_pass++;
    step();
  endtask

  task automatic test_bad_ap();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) ap(1'b1, 32'h11, 3'd1); else ap(1'b0, 32'h1 << (ADDR_W+2), 3'd2);
      @(negedge clk);
      n_tot++; if (mem_en !== 1'b0) $display("FAIL bad%0d_mem_en got %b exp 0", i, mem_en); else n_pass++;
      step(); idle();
      @(negedge clk);
      n_tot++; if ({hreadyout, hresp} !== 2'b01) $display("FAIL bad%0d_err1 got rdy%b resp%b exp 0 1", i, hreadyout, hresp); else n_pass++;
      step();
      @(negedge clk);
      n_tot++; if ({hreadyout, hresp, err_cnt} !== {2'b11, 8'(2+i)})
        $display("FAIL bad%0d_err2 got rdy%b resp%b cnt%0d exp 1 1 %0d", i, hreadyout, hresp, err_cnt, 2+i); else n_pass++;
      step();
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 253; i++) begin
      ap(1'b0, 32'h2, 3'd2);
      step(); idle(); step(); step();
      if (i == 251) begin
        @(negedge clk);
        n_tot++; if (err_cnt !== 8'hFF) $display("FAIL sat_reach got %0d exp 255", err_cnt); else n_pass++;
        step();
      end
    end
    @(negedge clk);
    n_tot++; if (err_cnt !== 8'hFF) $display("FAIL sat_hold got %0d exp 255", err_cnt); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    ap(1'b1, 32'h40, 3'd2);
    step(); idle(); hwdata = 32'h0BAD0BAD; rst = 1'b1;
    step(); rst = 1'b0; hwdata = '0;
    @(negedge clk);
    n_tot++; if ({hreadyout, hresp, mem_en, err_cnt} !== {2'b10, 1'b0, 8'd0})
      $display("FAIL rst_wr got rdy%b resp%b en%b cnt%0d exp 1 0 0 0", hreadyout, hresp, mem_en, err_cnt); else n_pass++;
    step(); ap(1'b1, 32'h40, 3'd2);
    step(); ap(1'b0, 32'h40, 3'd2); hwdata = 32'h12345678;
    step(); idle(); hwdata = '0; rst = 1'b1;
    @(negedge clk);
    n_tot++; if (hreadyout !== 1'b0) $display("FAIL rst_in_raw got rdy%b exp 0", hreadyout); else n_pass++;
    step(); rst = 1'b0;
    @(negedge clk);
    n_tot++; if ({hreadyout, hresp, mem_en, hrdata} !== {3'b100, 32'd0})
      $display("FAIL rst_raw got rdy%b resp%b en%b d%h exp 1 0 0 0", hreadyout, hresp, mem_en, hrdata); else n_pass++;
    step(); ap(1'b1, 32'h44, 3'd2); rst = 1'b1;
    step(); rst = 1'b0; idle(); hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    n_tot++; if (mem_en !== 1'b0) $display("FAIL rst_drop got en%b exp 0", mem_en); else n_pass++;
    step(); hwdata = '0;
  endtask

  task automatic test_wcheck();
    logic [6:0] ck;
    ap(1'b1, 32'h30, 3'd2);
    step(); idle(); hwdata = 32'hCAFEF00D;
`ifdef AHB_MEM_WCHECK_EN
    ck = secded_encode(32'hCAFEF00D) ^ 7'h01; hwdcheck = ck;
    @(negedge clk);
    n_tot++; if ({hreadyout, hresp, mem_en} !== 3'b010) $display("FAIL wchk_err1 got rdy%b resp%b en%b exp 0 1 0", hreadyout, hresp, mem_en); else n_pass++;
    step(); hwdata = '0;
    @(negedge clk);
    n_tot++; if ({hreadyout, hresp, err_cnt} !== {2'b11, 8'd1}) $display("FAIL wchk_err2 got rdy%b resp%b cnt%0d exp 1 1 1", hreadyout, hresp, err_cnt); else n_pass++;
`else
    ck = 7'h55 ^ 7'h01; hwdcheck = ck;
    @(negedge clk);
    n_tot++; if ({hreadyout, hresp, mem_en, mem_we, mem_wcheck} !== {4'b1011, ck})
      $display("FAIL wchk_wr got rdy%b resp%b en%b we%b c%h exp 1 0 1 1 %h", hreadyout, hresp, mem_en, mem_we, mem_wcheck, ck); else n_pass++;
    step(); hwdata = '0; ap(1'b0, 32'h30, 3'd2); sb.push_back('{32'hCAFEF00D, ck});
    step(); idle();
    @(negedge clk);
    e = (sb.size() != 0) ? sb.pop_front() : '{32'hx, 7'hx};
    n_tot++; if ({hreadyout, hrdata, hrdcheck} !== {1'b1, e.d, e.c})
      $display("FAIL wchk_rd got rdy%b %h/%h exp rdy1 %h/%h", hreadyout, hrdata, hrdcheck, e.d, e.c); else n_pass++;
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_word_write_read();
    test_raw();
    test_back_to_back();
    test_parity_err();
    test_bad_ap();
    test_saturate();
    test_reset_mid();
    test_wcheck();
    n_tot++; if (sb.size() != 0) $display("FAIL sb_drain got %0d left exp 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_mem_responder.md
Name: ahb_mem_responder

Overview:
- AHB-Lite subordinate (responder) placed in front of a single-port synchronous SRAM word array, 32 data bits plus 7 SECDED checksum bits per word.
- It is the far end of the core's data-bus initiator. It checks address/control parity, stores the write checksum supplied by the initiator, and returns the stored checksum with read data.
- It performs no ECC correction; correction stays in the core.
- Zero-wait reads and writes, except for a read that directly follows a write (1 wait) and error responses (2-cycle).

Parameters:
- ADDR_W, 12, number of word-address bits; memory holds 2^ADDR_W words.
- ERRCNT_W, 8, width of the saturating error-response counter.

Ports:
- s_clk_i  in  1  clock
- s_reset_i  in  1  reset
- s_hsel_i  in  1  responder select
- s_haddr_i  in  32  address
- s_htrans_i  in  2  transfer type
- s_hsize_i  in  3  transfer size
- s_hwrite_i  in  1  write indicator
- s_hready_i  in  1  bus-level HREADY (previous transfer finished)
- s_hparity_i  in  6  address/control parity
- s_hwdata_i  in  32  write data (already lane-aligned by the initiator)
- s_hwdcheck_i  in  7  write-data checksum
- s_hrdata_o  out  32  read data
- s_hrdcheck_o  out  7  read-data checksum
- s_hreadyout_o  out  1  transfer done
- s_hresp_o  out  1  error response
- s_mem_en_o  out  1  SRAM enable
- s_mem_we_o  out  1  SRAM write
- s_mem_be_o  out  4  SRAM byte enables
- s_mem_addr_o  out  ADDR_W  SRAM word address
- s_mem_wdata_o  out  32  SRAM write data
- s_mem_wcheck_o  out  7  SRAM checksum write (always written whole)
- s_mem_rdata_i  in  32  SRAM read data, 1-cycle latency
- s_mem_rcheck_i  in  7  SRAM read checksum
- s_err_cnt_o  out  ERRCNT_W  saturating count of error responses

Behaviour:
- Clock and reset: single clock s_clk_i. s_reset_i is synchronous and active-high.
- Valid address phase (AP): s_hsel_i & s_htrans_i[1] & s_hready_i.
- Parity expected (even), identical to the initiator's generation:
  - p[3:0] = XOR of each haddr byte, with bit 0 for haddr[7:0];
  - p[4] = ^hsize ^ hwrite;
  - p[5] = ^htrans.
- AP is bad if any of the following holds:
  - parity mismatch;
  - hsize > 2;
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0;
  - haddr[31:ADDR_W+2] != 0.
- Bad AP: no SRAM access, state -> ERR1.
- FSM states: IDLE, RD, WR, RAW, ERR1, ERR2. Outputs per state:
  - IDLE: hreadyout=1, hresp=0.
  - RD: hreadyout=1; hrdata=s_mem_rdata_i; hrdcheck=s_mem_rcheck_i.
  - WR: hreadyout=1; SRAM write issued this cycle:
    - mem_en=1, we=1;
    - addr = latched word address;
    - be from latched size/addr[1:0] (byte: one-hot lane; half: 0011/1100; word: 1111);
    - wdata = hwdata; wcheck = hwdcheck.
  - RAW: hreadyout=0, hresp=0; SRAM read of latched address issued; -> RD.
  - ERR1: hreadyout=0, hresp=1; -> ERR2.
  - ERR2: hreadyout=1, hresp=1.
- Next state from a good AP (evaluated in IDLE, RD, WR, ERR2):
  - Read AP in IDLE, RD or ERR2: SRAM read issued combinationally that cycle (mem_en=1, addr=haddr[ADDR_W+1:2]); -> RD.
  - Read AP in WR: port busy; latch address; -> RAW.
  - Write AP: latch word address, size, addr[1:0]; -> WR.
- Next state with no valid AP: IDLE.
- In RAW and ERR1, s_hready_i is low, so no AP is sampled.
- hrdata/hrdcheck are driven 0 outside RD.
- Error counter: s_err_cnt_o increments on every entry to ERR1 and saturates at all-ones (no wrap).
- Reset, including mid-transfer: state IDLE, latched fields 0, counter 0, hreadyout=1, hresp=0, mem_en=0, all data outputs 0. Any pending write is dropped.

Optional Feature:
- Macro: AHB_MEM_WCHECK_EN.
- When defined, in WR the responder recomputes the checksum of s_hwdata_i (secded_encode) and compares it with s_hwdcheck_i. On mismatch:
  - SRAM write suppressed (mem_en=0);
  - hreadyout=0, hresp=1 this cycle (acts as ERR1), then ERR2;
  - counter increments.
- When undefined, the checksum is stored unchecked.

Decomposition:
- Shared package (p_hardisc): state enum ahb_resp_fsm (RESP_IDLE, RESP_RD, RESP_WR, RESP_RAW, RESP_ERR1, RESP_ERR2) and HTRANS constants (IDLE=2'b00, NONSEQ=2'b10).
- One natural sub-module: ahb_parity_check (combinational; 6-bit expected parity + mismatch flag). It can be reused by other responders.
- secded_encode is reused from the existing code for the optional check.

Test Plan:
- Word write 0xDEADBEEF, check 0x2A to addr 0x10, then read 0x10 with 1 idle cycle -> mem be=1111, addr=4; read returns 0xDEADBEEF/0x2A with zero wait.
- Byte write to 0x13, then immediate read of 0x10 -> be=1000; read data phase has one hreadyout=0 cycle (RAW), then data.
- Read AP with s_hparity_i[2] flipped -> ERR1 (hreadyout=0, hresp=1), ERR2 (1,1); no mem_en; s_err_cnt_o=1.
- Half write to 0x11 and AP to haddr=1<<(ADDR_W+2) -> both get 2-cycle error; force counter to 0xFF, third error -> stays 0xFF.
- Assert reset during WR and RAW -> next cycle IDLE outputs, mem_en=0, counter 0.
- With AHB_MEM_WCHECK_EN: word write with hwdcheck XOR 0x01 -> no SRAM write, 2-cycle error; without the macro, same stimulus -> written, hreadyout=1.
